// File: rtl/oneshot_arb_pkg.sv
// oneshot_arb_pkg: shared types and helpers for oneshot_arbiter.
//   state_t  - arbiter FSM state (IDLE, COUNT, END), encoded from ST_* constants
//   pick_t   - result of a round-robin search {found, idx}
//   rr_pick  - first set pending bit searching upward from rr+1, modulo n
package oneshot_arb_pkg;

  localparam int MAX_CH = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_END   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    COUNT = ST_COUNT,
    END   = ST_END
  } state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // Search n channels starting just after rr. Bits at or above n are ignored,
  // so callers zero-extend their pending vector to MAX_CH.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0] pending,
                                    input logic [3:0]        rr,
                                    input int unsigned       n);
    pick_t       p;
    int unsigned c;
    p = '0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      c = (32'(rr) + k) % n;
      if (k <= n && !p.found && pending[c[3:0]]) begin
        p.found = 1'b1;
        p.idx   = c[3:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/oneshot_arbiter_if.sv
// oneshot_arbiter_if: requester/consumer signal bundle of oneshot_arbiter.
//   TRG      per-channel trigger (rising edge requests a pulse)
//   CLR_N    per-channel active-low clear
//   Q / Q_N  per-channel pulse output and its complement
//   BUSY     timer granted
//   GRANT_ID index of the granted (or last granted) channel
// master drives triggers/clears, slave (the arbiter) drives the outputs.
interface oneshot_arbiter_if #(
  parameter int NUM_CH   = 4,
  parameter int ID_WIDTH = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]   TRG;
  logic [NUM_CH-1:0]   CLR_N;
  logic [NUM_CH-1:0]   Q;
  logic [NUM_CH-1:0]   Q_N;
  logic                BUSY;
  logic [ID_WIDTH-1:0] GRANT_ID;

  modport master (output TRG, CLR_N, input Q, Q_N, BUSY, GRANT_ID);
  modport slave  (input TRG, CLR_N, output Q, Q_N, BUSY, GRANT_ID);
endinterface

// File: rtl/oneshot_edge_det.sv
// oneshot_edge_det: registered rising-edge detector for one trigger line.
//   clk_i  clock
//   rst_i  synchronous active-high reset (previous value forced low)
//   trg_i  trigger input
//   det_o  high in the cycle trg_i is high and was low the cycle before
module oneshot_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic trg_i,
  output logic det_o
);
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= 1'b0;
    else       prev_q <= trg_i;
  end

  assign det_o = trg_i & ~prev_q;
endmodule

// File: rtl/oneshot_arbiter.sv
// oneshot_arbiter: one shared one-shot timer, round-robin granted to NUM_CH
// edge-triggered requesters. The granted channel's Q is high for COUNTS clocks.
//   CLK       system clock
//   RESET     synchronous active-high reset
//   bus       oneshot_arbiter_if.slave: TRG, CLR_N in; Q, Q_N, BUSY, GRANT_ID out
// Build option: define ONESHOT_ARB_RETRIG_EN to make a new edge on the active
// channel restart its pulse; otherwise such an edge is dropped.
module oneshot_arbiter import oneshot_arb_pkg::*; #(
  parameter int NUM_CH    = 4,
  parameter int COUNTS    = 1000,
  parameter int BIT_WIDTH = $clog2(COUNTS),
  parameter int ID_WIDTH  = $clog2(NUM_CH)
) (
  input  logic               CLK,
  input  logic               RESET,
  oneshot_arbiter_if.slave   bus
);

  state_t                state_q, state_d;
  logic [BIT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0]     pend_q, pend_d;
  logic [ID_WIDTH-1:0]   gid_q, gid_d;
  logic [ID_WIDTH-1:0]   rr_q, rr_d;
  logic [NUM_CH-1:0]     det;
  logic                  busy;
  logic                  gnt;
  pick_t                 pick;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_det
    oneshot_edge_det u_det (
      .clk_i (CLK),
      .rst_i (RESET),
      .trg_i (bus.TRG[i]),
      .det_o (det[i])
    );
  end

  assign busy = (state_q == COUNT);
  assign pick = rr_pick(MAX_CH'(pend_q), 4'(rr_q), NUM_CH);
  assign gnt  = (state_q == IDLE) && pick.found;

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!bus.CLR_N[i])
        pend_d[i] = 1'b0;
      // an edge on the channel currently pulsing never queues another pulse
      else if (det[i] && !(busy && gid_q == ID_WIDTH'(i)))
        pend_d[i] = 1'b1;
      else if (gnt && pick.idx == 4'(i))
        pend_d[i] = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick.found) begin
          gid_d   = ID_WIDTH'(pick.idx);
          rr_d    = ID_WIDTH'(pick.idx);
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (!bus.CLR_N[gid_q])
          state_d = END;
`ifdef ONESHOT_ARB_RETRIG_EN
        else if (det[gid_q])
          cnt_d = '0;                     // restart: COUNTS more cycles from here
`endif
        else if (cnt_q == BIT_WIDTH'(COUNTS - 1))
          state_d = END;                  // no increment on the last cycle: no wrap
        else
          cnt_d = cnt_q + BIT_WIDTH'(1);
      end
      END: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      gid_q   <= '0;
      rr_q    <= ID_WIDTH'(NUM_CH - 1);  // first search starts at channel 0
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.Q        = busy ? (NUM_CH'(1) << gid_q) : '0;
  assign bus.Q_N      = ~bus.Q;
  assign bus.BUSY     = busy;
  assign bus.GRANT_ID = gid_q;

endmodule
